bitbrick_psum_accum: RTL and testbench

- Consumer end of the BitBrick multiplier output interface.
- Takes the 8-bit product word P from a fused 4x4 BitBrick tile, one beat per cycle under valid/ready, and unpacks it per precision mode.
- Accumulates products over a group terminated by in_last, then presents the finished partial sum(s) to the systolic-array drain path.
- 4-bit mode: P is one 8-bit product. 2-bit mode: P packs two independent 4-bit products, high lane in P[7:4] and low lane in P[3:0].

---
 rtl/bitbrick_psum_accum.sv | 174 +++++++++++++++++
 tb/tb_bitbrick_psum_accum.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitbrick_psum_accum.sv
// Partial-sum accumulator at the consumer end of a fused 4x4 BitBrick multiplier.
// Unpacks each product beat per precision mode and sums a group closed by in_last.
module bitbrick_psum_accum #(
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  input  logic             in_mode,
  input  logic             in_signed,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc0,
  output logic [ACC_W-1:0] out_acc1,
  output logic             out_mode,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [ACC_W-1:0]   r_acc0;
  logic [ACC_W-1:0]   r_acc1;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode;
  logic               r_sign;
  logic               r_err;

  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_acc0;
  logic [ACC_W-1:0]   r_out_acc1;
  logic               r_out_mode;
  logic [CNT_W-1:0]   r_out_count;
  logic               r_out_err;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_first;
  logic               w_lock_mode;
  logic               w_lock_sign;
  logic [ACC_W-1:0]   w_term0;
  logic [ACC_W-1:0]   w_term1;
  logic [ACC_W-1:0]   w_sum0;
  logic [ACC_W-1:0]   w_sum1;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_err_next;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    unique case (r_state)
      S_IDLE, S_ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_next_state = S_HOLD;
        end else if (in_valid) begin
          w_next_state = S_ACC;
        end
      end
      S_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Never advertise room while reset is held, even though the state already reads IDLE.
  assign in_ready = w_in_ready & ~reset;
  assign w_accept = in_valid & in_ready;

  // The first beat of a group sets the mode/sign; later beats reuse the locked values.
  assign w_first     = (r_state == S_IDLE);
  assign w_lock_mode = w_first ? in_mode   : r_mode;
  assign w_lock_sign = w_first ? in_signed : r_sign;

  always_comb begin
    w_term0 = '0;
    w_term1 = '0;
    if (w_lock_mode) begin
      w_term0 = {{(ACC_W-8){w_lock_sign & in_p[7]}}, in_p};
    end else begin
      w_term0 = {{(ACC_W-4){w_lock_sign & in_p[3]}}, in_p[3:0]};
      w_term1 = {{(ACC_W-4){w_lock_sign & in_p[7]}}, in_p[7:4]};
    end
  end

  assign w_sum0 = (w_first ? '0 : r_acc0) + w_term0;
  assign w_sum1 = (w_first ? '0 : r_acc1) + w_term1;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_first) begin
      w_cnt_next = CNT_W'(1);
    end else if (!(&r_cnt)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  assign w_err_next = !w_first &&
                      (r_err || (in_mode != r_mode) || (in_signed != r_sign));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: all datapath registers are reset so a group cut short by reset leaves no residue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc0 <= '0;
      r_acc1 <= '0;
      r_cnt  <= '0;
      r_mode <= 1'b0;
      r_sign <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_acc0 <= w_sum0;
      r_acc1 <= w_sum1;
      r_cnt  <= w_cnt_next;
      r_err  <= w_err_next;
      if (w_first) begin
        r_mode <= in_mode;
        r_sign <= in_signed;
      end
    end
  end

  // Result registers load on the closing beat and stay frozen until the drain handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_acc0  <= '0;
      r_out_acc1  <= '0;
      r_out_mode  <= 1'b0;
      r_out_count <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept && in_last) begin
      r_out_valid <= 1'b1;
      r_out_acc0  <= w_sum0;
      r_out_acc1  <= w_sum1;
      r_out_mode  <= w_lock_mode;
      r_out_count <= w_cnt_next;
      r_out_err   <= w_err_next;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_acc0  = r_out_acc0;
  assign out_acc1  = r_out_acc1;
  assign out_mode  = r_out_mode;
  assign out_count = r_out_count;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_bitbrick_psum_accum.sv
// Self-checking bench for bitbrick_psum_accum: directed cases plus randomized groups
// compared against an arithmetic model of the group sums.
module tb_bitbrick_psum_accum;

  localparam int ACC_W = 20;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_p;
  logic             in_mode;
  logic             in_signed;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc0;
  logic [ACC_W-1:0] out_acc1;
  logic             out_mode;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  bitbrick_psum_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_mode   (in_mode),
    .in_signed (in_signed),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc0  (out_acc0),
    .out_acc1  (out_acc1),
    .out_mode  (out_mode),
    .out_count (out_count),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Beats accepted in the group currently being built.
  logic [7:0] q_p[$];
  bit         q_mode[$];
  bit         q_sgn[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One lane's contribution, as a signed integer wrapped to the accumulator width.
  function automatic logic [ACC_W-1:0] lane_term(input logic [7:0] p, input bit m, input bit s,
                                                 input bit hi);
    int v;
    if (m) begin
      if (hi) return '0;
      v = int'(p);
      if (s && v >= 128) v -= 256;
    end else begin
      v = hi ? int'(p) / 16 : int'(p) % 16;
      if (s && v >= 8) v -= 16;
    end
    return ACC_W'(v);
  endfunction

  task automatic send_beat(input logic [7:0] p, input bit m, input bit s, input bit l);
    bit ok = 0;
    in_valid  = 1'b1;
    in_p      = p;
    in_mode   = m;
    in_signed = s;
    in_last   = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) ok = 1;
      @(posedge clock);
      #1;
    end
    in_valid  = 1'b0;
    in_p      = 8'($urandom);
    in_mode   = 1'($urandom);
    in_signed = 1'($urandom);
    in_last   = 1'($urandom);
    if (ok) begin
      q_p.push_back(p);
      q_mode.push_back(m);
      q_sgn.push_back(s);
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Called right after the closing beat; checks latency, result fields, hold and drain.
  task automatic expect_group(input string tag, input int hold_cycles);
    logic [ACC_W-1:0] e0 = '0;
    logic [ACC_W-1:0] e1 = '0;
    bit               em;
    bit               es;
    bit               eerr = 0;
    int               ecnt;
    em = q_mode[0];
    es = q_sgn[0];
    foreach (q_p[i]) begin
      e0 += lane_term(q_p[i], em, es, 1'b0);
      e1 += lane_term(q_p[i], em, es, 1'b1);
      if (q_mode[i] != em || q_sgn[i] != es) eerr = 1;
    end
    ecnt = (q_p.size() > 255) ? 255 : q_p.size();
    q_p.delete();
    q_mode.delete();
    q_sgn.delete();

    @(negedge clock);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".acc0"},  32'(out_acc0),  32'(e0));
    check({tag, ".acc1"},  32'(out_acc1),  32'(e1));
    check({tag, ".mode"},  32'(out_mode),  32'(em));
    check({tag, ".count"}, 32'(out_count), 32'(ecnt));
    check({tag, ".err"},   32'(out_err),   32'(eerr));
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clock);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_acc0"},  32'(out_acc0), 32'(e0));
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check({tag, ".drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".drain_ready"}, 32'(in_ready),  32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_p      = '0;
    in_mode   = 1'b0;
    in_signed = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.acc0",      32'(out_acc0),  32'd0);
    check("rst.acc1",      32'(out_acc1),  32'd0);
    check("rst.count",     32'(out_count), 32'd0);
    check("rst.mode",      32'(out_mode),  32'd0);
    check("rst.err",       32'(out_err),   32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 4-bit unsigned: 3 x 225 = 675
    send_beat(8'd225, 1, 0, 0);
    send_beat(8'd225, 1, 0, 0);
    send_beat(8'd225, 1, 0, 1);
    expect_group("u4", 0);

    // 2-bit signed: high lane -1 twice, low lane 3 twice
    send_beat(8'hF3, 0, 1, 0);
    send_beat(8'hF3, 0, 1, 1);
    expect_group("s2", 1);

    send_beat(8'h80, 1, 1, 1);
    expect_group("s4_single", 0);

    // Mode change mid-group: second beat still unpacked as 4-bit
    send_beat(8'd10,  1, 0, 0);
    send_beat(8'h21,  0, 0, 1);
    expect_group("mode_err", 0);

    // Backpressure with a pending beat waiting behind the held result
    send_beat(8'd7, 1, 0, 1);
    q_p.delete();
    q_mode.delete();
    q_sgn.delete();
    in_valid  = 1'b1;
    in_p      = 8'd5;
    in_mode   = 1'b1;
    in_signed = 1'b0;
    in_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.acc0",      32'(out_acc0),  32'd7);
      check("bp.count",     32'(out_count), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    check("bp.drain_valid", 32'(out_valid), 32'd0);
    check("bp.drain_ready", 32'(in_ready),  32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    q_p.push_back(8'd5);
    q_mode.push_back(1'b1);
    q_sgn.push_back(1'b0);
    expect_group("bp_pending", 0);

    // Reset mid-group discards the partial sum
    send_beat(8'd99, 1, 0, 0);
    send_beat(8'd42, 1, 0, 0);
    q_p.delete();
    q_mode.delete();
    q_sgn.delete();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.acc0",      32'(out_acc0),  32'd0);
    check("mid_rst.count",     32'(out_count), 32'd0);
    check("mid_rst.in_ready",  32'(in_ready),  32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    send_beat(8'd5, 1, 0, 1);
    expect_group("post_rst", 0);

    // Counter saturation over a long group
    for (int i = 0; i < 300; i++) send_beat(8'd255, 1, 0, (i == 299));
    expect_group("sat", 0);

    // Randomized groups with idle gaps and occasional mode/sign flips
    for (int g = 0; g < 40; g++) begin
      int len = $urandom_range(1, 8);
      bit m   = 1'($urandom);
      bit s   = 1'($urandom);
      for (int b = 0; b < len; b++) begin
        bit bm = m;
        bit bs = s;
        if (b > 0 && $urandom_range(0, 9) == 0) bm = ~m;
        if (b > 0 && $urandom_range(0, 9) == 0) bs = ~s;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock);
          #1;
        end
        send_beat(8'($urandom), bm, bs, (b == len - 1));
      end
      expect_group($sformatf("rnd%0d", g), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
